// File: rtl/spm_pkg.sv
// Shared types and constants for the SPM scheduler: FSM state encoding,
// default operand width and the sequencing-counter width helper.
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int SPM_SIZE_DEF = 32;

  // Counter must reach 2*size inclusive.
  function automatic int cnt_w(input int size);
    return $clog2(2 * size + 1);
  endfunction

endpackage

// File: rtl/spm.sv
// Serial-parallel multiplier core: x parallel, y serial LSB-first, p serial
// LSB-first one cycle behind y. Signed x; feed sign-extended y for 2*SIZE bits.
module spm #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] x,
  input  logic            y,
  output logic            p
);

  logic [SIZE-1:0] r_acc;
  logic [SIZE:0]   w_sum;

  // Partial remainder stays within SIZE signed bits; one extra bit for the add.
  assign w_sum = {r_acc[SIZE-1], r_acc} + (y ? {x[SIZE-1], x} : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      p     <= 1'b0;
    end else begin
      r_acc <= w_sum[SIZE:1];
      p     <= w_sum[0];
    end
  end

endmodule

// File: rtl/spm_rr_arb.sv
// NREQ-wide arbiter with one-hot grant. Round-robin with a last-grant pointer
// when SPM_SCHED_RR_EN is defined, otherwise fixed priority (lowest index wins).
module spm_rr_arb #(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
`ifdef SPM_SCHED_RR_EN
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            i_adv,
`endif
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_gidx
);

  logic [IW-1:0] w_idx;
  logic          w_found;

`ifdef SPM_SCHED_RR_EN
  logic [IW-1:0] r_ptr;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)   r_ptr <= IW'(NREQ - 1);
    else if (i_adv) r_ptr <= o_gidx;
  end
`endif

  always_comb begin
    o_gnt   = '0;
    o_gidx  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef SPM_SCHED_RR_EN
      w_idx = IW'((int'(r_ptr) + 1 + k) % NREQ);
`else
      w_idx = IW'(k);
`endif
      if (!w_found && i_req[w_idx]) begin
        w_found       = 1'b1;
        o_gnt[w_idx]  = 1'b1;
        o_gidx        = w_idx;
      end
    end
  end

endmodule

// File: rtl/spm_sched.sv
// Arbitrates NREQ requesters onto one shared SPM core and sequences a full
// 2*SIZE-bit signed product. Optional round-robin arbitration: SPM_SCHED_RR_EN.
module spm_sched
  import spm_pkg::*;
#(
  parameter  int SIZE = SPM_SIZE_DEF,
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW   = cnt_w(SIZE)
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] x_in,
  input  logic [NREQ*SIZE-1:0] y_in,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic [2*SIZE-1:0]    prod,
  output logic                 busy
);

  state_t             r_state, w_nxt;
  logic [SIZE-1:0]    r_x, r_y;
  logic [CW-1:0]      r_cnt;
  logic               r_clr_q;
  logic [IW-1:0]      r_gsel;
  logic [NREQ-1:0]    r_ack, r_done;
  logic [2*SIZE-1:0]  r_prod;

  logic               w_any, w_last, w_take;
  logic [NREQ-1:0]    w_gnt;
  logic [IW-1:0]      w_gidx;
  logic               w_spm_rst, w_spm_y, w_spm_p;

  assign w_any  = |req;
  assign w_take = (r_state == IDLE) && w_any;
  assign w_last = (r_cnt == CW'(2 * SIZE));

  spm_rr_arb #(.NREQ(NREQ)) u_arb (
`ifdef SPM_SCHED_RR_EN
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .i_adv   (w_take),
`endif
    .i_req   (req),
    .o_gnt   (w_gnt),
    .o_gidx  (w_gidx)
  );

  // Clear comes from a dedicated flop so the SPM reset is glitch-free.
  assign w_spm_rst = ~HRESETn | r_clr_q;
  assign w_spm_y   = (r_state == RUN) & r_y[0];

  spm #(.SIZE(SIZE)) u_spm (
    .clk (HCLK),
    .rst (w_spm_rst),
    .x   (r_x),
    .y   (w_spm_y),
    .p   (w_spm_p)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_nxt = CLR;
      CLR:     w_nxt = RUN;
      RUN:     if (w_last) w_nxt = DONE;
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_clr_q <= 1'b0;
      r_gsel  <= '0;
      r_ack   <= '0;
      r_done  <= '0;
      r_prod  <= '0;
    end else begin
      r_ack  <= '0;
      r_done <= '0;
      case (r_state)
        IDLE: if (w_any) begin
          r_x     <= x_in[int'(w_gidx)*SIZE +: SIZE];
          r_y     <= y_in[int'(w_gidx)*SIZE +: SIZE];
          r_gsel  <= w_gidx;
          r_clr_q <= 1'b1;
          r_ack   <= w_gnt;
        end
        CLR: begin
          r_prod  <= '0;
          r_cnt   <= '0;
          r_clr_q <= 1'b0;
        end
        RUN: begin
          // Arithmetic shift sign-extends y into the upper SIZE serial bits.
          r_y   <= {r_y[SIZE-1], r_y[SIZE-1:1]};
          r_cnt <= r_cnt + 1'b1;
          // p trails y by one cycle, so the first product bit lands at CNT=1.
          if (r_cnt != '0) r_prod <= {w_spm_p, r_prod[2*SIZE-1:1]};
          if (w_last)      r_done[r_gsel] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ack  = r_ack;
  assign done = r_done;
  assign prod = r_prod;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_spm_sched.sv
// Directed self-checking bench for spm_sched: vector table of single
// operations, mid-run reset, and two-requester arbitration sequence.
module tb_spm_sched;
  localparam int SIZE = 32;
  localparam int NREQ = 2;

  logic                 HCLK = 1'b0;
  logic                 HRESETn = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*SIZE-1:0] x_in = '0;
  logic [NREQ*SIZE-1:0] y_in = '0;
  logic [NREQ-1:0]      ack, done;
  logic [2*SIZE-1:0]    prod;
  logic                 busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int          id;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] p;
  } vec_t;
  vec_t vecs[7];

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  spm_sched #(.SIZE(SIZE), .NREQ(NREQ)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .req     (req),
    .x_in    (x_in),
    .y_in    (y_in),
    .ack     (ack),
    .done    (done),
    .prod    (prod),
    .busy    (busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // One full operation from a single requester, checking ack, latency, result.
  task automatic run_op(input string nm, input int id, input logic [31:0] xv,
                        input logic [31:0] yv, input logic [63:0] ev);
    int lat;
    @(negedge HCLK);
    x_in[id*SIZE +: SIZE] = xv;
    y_in[id*SIZE +: SIZE] = yv;
    req[id] = 1'b1;
    @(negedge HCLK);
    chk({nm, "_ack"}, 64'(ack), 64'(oh(id)));
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    req[id] = 1'b0;
    lat = 0;
    while (done == '0 && lat < 200) begin
      @(negedge HCLK);
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'd66);
    chk({nm, "_done"}, 64'(done), 64'(oh(id)));
    chk({nm, "_prod"}, prod, ev);
    @(negedge HCLK);
    chk({nm, "_done_off"}, 64'(done), 64'd0);
    chk({nm, "_idle"}, 64'(busy), 64'd0);
    chk({nm, "_hold"}, prod, ev);
  endtask

  initial begin
    int w, tprev, seen;
    int exp_g[4];
    logic [63:0] pexp[2];

    vecs[0] = '{0, 32'd5,          32'd7,          64'd35};
    vecs[1] = '{1, 32'hFFFF_FFF1,  32'd20,         64'hFFFF_FFFF_FFFF_FED4};
    vecs[2] = '{0, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
    vecs[3] = '{1, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFF_8000_0001};
    vecs[4] = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'd1};
    vecs[5] = '{1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h0000_0000_8000_0000};
    vecs[6] = '{0, 32'd0,          32'd12345678,   64'd0};

    // Reset state
    #12;
    chk("rst_ack",  64'(ack),  64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_prod", prod,      64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("v%0d", i), vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].p);

    // Reset in the middle of RUN (CNT=20)
    @(negedge HCLK);
    x_in[0 +: SIZE] = 32'd123456;
    y_in[0 +: SIZE] = 32'd789;
    req[0] = 1'b1;
    @(negedge HCLK);
    req[0] = 1'b0;
    repeat (21) @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_ack",  64'(ack),  64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_prod", prod,      64'd0);
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    seen = 0;
    repeat (70) begin
      @(negedge HCLK);
      if (done != '0 || busy) seen++;
    end
    chk("mid_rst_quiet", 64'(seen), 64'd0);
    run_op("post_rst", 1, 32'd3, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4);

    // Both requesters held continuously
`ifdef SPM_SCHED_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    pexp[0] = 64'd18;
    pexp[1] = 64'hFFFF_FFFF_FFFF_FFEE;
    @(negedge HCLK);
    x_in = {32'd9, 32'd6};
    y_in = {32'hFFFF_FFFE, 32'd3};
    req  = 2'b11;
    tprev = 0;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (ack == '0 && w < 200) begin
        @(negedge HCLK);
        w++;
      end
      chk($sformatf("arb%0d_ack", k), 64'(ack), 64'(oh(exp_g[k])));
      w = 0;
      while (done == '0 && w < 200) begin
        @(negedge HCLK);
        w++;
      end
      chk($sformatf("arb%0d_done", k), 64'(done), 64'(oh(exp_g[k])));
      chk($sformatf("arb%0d_prod", k), prod, pexp[exp_g[k]]);
      if (k > 0) chk($sformatf("arb%0d_gap", k), 64'(cyc - tprev), 64'd68);
      tprev = cyc;
    end
    req = '0;
    @(negedge HCLK);
    @(negedge HCLK);
    chk("arb_end_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
